decode38_hold: RTL and testbench

Registered 3-to-8 decoder with per-line hold timers: the receive-side counterpart of the 8-to-3 priority encoder. It takes an encoded index plus its "any input" flag and re-expands it to one-hot. Each decoded line is stretched so short events stay visible on board LEDs. It sits between the encoder output (or any 3-bit event source) and the LED/seven-segment pins of the board top.

---
 rtl/decode38_hold.sv | 142 ++++++++++++++
 tb/tb_decode38_hold.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode38_hold.sv
// decode38_hold: registered 3-to-8 decoder with per-line hold timers.
// An accepted (ena & code_valid) index produces a one-cycle one-hot hit pulse
// and reloads that line's hold counter so the stretched output y stays
// visible for HOLD_CYCLES cycles.
// Optional feature: define DEC38_SEG_EN to add a registered active-low
// seven-segment output showing the most recent accepted index.
module decode38_hold #(
  parameter int HOLD_W      = 4,
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] code,
  input  logic       code_valid,
  output logic [7:0] hit,
  output logic [7:0] y,
  output logic [2:0] last_code,
  output logic       last_valid,
  output logic [7:0] evt_cnt
`ifdef DEC38_SEG_EN
  ,
  output logic [7:0] seg
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic              accept;
  logic [7:0]        hitQ, hitD;
  logic [HOLD_W-1:0] cntQ [8];
  logic [HOLD_W-1:0] cntD [8];
  logic [2:0]        lastCodeQ, lastCodeD;
  logic              lastValidQ, lastValidD;
  logic [7:0]        evtCntQ, evtCntD;
  logic [7:0]        yLines;

  assign accept = ena & code_valid;

  // Next-state for the hold counters: a hit on a line reloads it (retrigger),
  // every other line keeps decaying toward zero independently.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cntD[i] = cntQ[i];
      if (accept && (code == 3'(i))) begin
        cntD[i] = HOLD_LOAD;
      end else if (cntQ[i] != '0) begin
        cntD[i] = cntQ[i] - HOLD_ONE;
      end
    end
  end

  // Next-state for the hit pulse and the event bookkeeping; ena=0 freezes
  // the bookkeeping because nothing is accepted.
  always_comb begin
    hitD       = 8'd0;
    lastCodeD  = lastCodeQ;
    lastValidD = lastValidQ;
    evtCntD    = evtCntQ;
    if (accept) begin
      hitD       = 8'd1 << code;
      lastCodeD  = code;
      lastValidD = 1'b1;
      evtCntD    = evtCntQ + 8'd1;
    end
  end

  // State registers, cleared asynchronously so a reset mid-hold blanks the lines at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitQ       <= 8'd0;
      lastCodeQ  <= 3'd0;
      lastValidQ <= 1'b0;
      evtCntQ    <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        cntQ[i] <= '0;
      end
    end else begin
      hitQ       <= hitD;
      lastCodeQ  <= lastCodeD;
      lastValidQ <= lastValidD;
      evtCntQ    <= evtCntD;
      for (int i = 0; i < 8; i++) begin
        cntQ[i] <= cntD[i];
      end
    end
  end

  // A stretched line is simply "its counter has not run out yet".
  always_comb begin
    yLines = 8'd0;
    for (int i = 0; i < 8; i++) begin
      yLines[i] = (cntQ[i] != '0);
    end
  end

  assign hit        = hitQ;
  assign y          = yLines;
  assign last_code  = lastCodeQ;
  assign last_valid = lastValidQ;
  assign evt_cnt    = evtCntQ;

`ifdef DEC38_SEG_EN
  logic [7:0] segQ, segD;

  function automatic logic [6:0] segPattern(input logic [2:0] idx);
    logic [6:0] pat;
    case (idx)
      3'd0:    pat = 7'b1000000;
      3'd1:    pat = 7'b1111001;
      3'd2:    pat = 7'b0100100;
      3'd3:    pat = 7'b0110000;
      3'd4:    pat = 7'b0011001;
      3'd5:    pat = 7'b0010010;
      3'd6:    pat = 7'b0000010;
      default: pat = 7'b1111000;
    endcase
    return pat;
  endfunction

  // The display follows the latest accepted index with the decimal point kept off.
  always_comb begin
    segD = segQ;
    if (accept) begin
      segD = {1'b1, segPattern(code)};
    end
  end

  // Display register, blank until the first accepted event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segQ <= 8'hFF;
    end else begin
      segQ <= segD;
    end
  end

  assign seg = segQ;
`endif

endmodule

// File: tb/tb_decode38_hold.sv
// tb_decode38_hold: directed scenarios plus randomized traffic against a
// timestamp-based reference model of decode38_hold.
// Honours DEC38_SEG_EN in the same way as the design.
module tb_decode38_hold;

  localparam int HOLD_W      = 4;
  localparam int HOLD_CYCLES = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] code = 3'd0;
  logic       code_valid = 1'b0;
  logic [7:0] hit;
  logic [7:0] y;
  logic [2:0] last_code;
  logic       last_valid;
  logic [7:0] evt_cnt;
`ifdef DEC38_SEG_EN
  logic [7:0] seg;
`endif

  int total = 0;
  int bad   = 0;

  decode38_hold #(.HOLD_W(HOLD_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .code       (code),
    .code_valid (code_valid),
    .hit        (hit),
    .y          (y),
    .last_code  (last_code),
    .last_valid (last_valid),
    .evt_cnt    (evt_cnt)
`ifdef DEC38_SEG_EN
    ,
    .seg        (seg)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model: each line remembers the edge of its last hit; a line is
  // lit while fewer than HOLD_CYCLES edges have passed since that hit.
  int         edgeNo;
  int         lastHitEdge [8];
  bit         everHit [8];
  logic [7:0] mHit;
  int         mCount;
  int         mLast;
  bit         mValid;

  logic [6:0] digitTable [8];
  initial begin
    digitTable[0] = 7'b1000000;
    digitTable[1] = 7'b1111001;
    digitTable[2] = 7'b0100100;
    digitTable[3] = 7'b0110000;
    digitTable[4] = 7'b0011001;
    digitTable[5] = 7'b0010010;
    digitTable[6] = 7'b0000010;
    digitTable[7] = 7'b1111000;
  end

  // Model update on every edge, and an immediate clear on reset assertion.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mHit   = 8'd0;
      mCount = 0;
      mLast  = 0;
      mValid = 0;
      for (int i = 0; i < 8; i++) begin
        everHit[i]     = 0;
        lastHitEdge[i] = 0;
      end
    end else begin
      edgeNo = edgeNo + 1;
      mHit   = 8'd0;
      if (ena && code_valid) begin
        mHit                = 8'd0;
        mHit[code]          = 1'b1;
        everHit[code]       = 1;
        lastHitEdge[code]   = edgeNo;
        mCount              = (mCount + 1) % 256;
        mLast               = int'(code);
        mValid              = 1;
      end
    end
  end

  function automatic logic [7:0] modelY();
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (everHit[i] && (edgeNo - lastHitEdge[i]) < HOLD_CYCLES) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of every output against the model on the falling edge.
  always @(negedge clk) begin
    checkOutput("model_hit", 32'(hit), 32'(mHit));
    checkOutput("model_y", 32'(y), 32'(modelY()));
    checkOutput("model_last_code", 32'(last_code), 32'(mLast));
    checkOutput("model_last_valid", 32'(last_valid), 32'(mValid));
    checkOutput("model_evt_cnt", 32'(evt_cnt), 32'(mCount));
`ifdef DEC38_SEG_EN
    checkOutput("model_seg", 32'(seg), mValid ? 32'({1'b1, digitTable[mLast]}) : 32'hFF);
`endif
  end

  task automatic applyStimulus(input logic e, input logic [2:0] c, input logic v);
    @(negedge clk);
    #1;
    ena        = e;
    code       = c;
    code_valid = v;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    edgeNo = 0;
    $display("[TB] start");

    // Inputs driven while held in reset must not register.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 3'd5, 1'b1);
      checkOutput("rst_hold_hit", 32'(hit), 32'h0);
      checkOutput("rst_hold_y", 32'(y), 32'h0);
      checkOutput("rst_hold_evt", 32'(evt_cnt), 32'h0);
`ifdef DEC38_SEG_EN
      checkOutput("rst_hold_seg", 32'(seg), 32'hFF);
`endif
    end

    // First edge after release samples normally; then async reset mid-hold.
    applyStimulus(1'b1, 3'd5, 1'b1);
    rst_n = 1'b1;
    idle(1);
    checkOutput("rel_hit", 32'(hit), 32'h20);
    checkOutput("rel_y", 32'(y), 32'h20);
    checkOutput("rel_evt", 32'(evt_cnt), 32'd1);
    idle(3);
    checkOutput("pre_async_y", 32'(y), 32'h20);
    rst_n = 1'b0;
    #1;
    checkOutput("async_y", 32'(y), 32'h0);
    checkOutput("async_evt", 32'(evt_cnt), 32'h0);
    checkOutput("async_lvalid", 32'(last_valid), 32'h0);
    idle(1);
    rst_n = 1'b1;

    // Single event on line 3.
    applyStimulus(1'b1, 3'd3, 1'b1);
    idle(1);
    checkOutput("single_hit", 32'(hit), 32'h08);
    checkOutput("single_last", 32'(last_code), 32'd3);
    checkOutput("single_evt", 32'(evt_cnt), 32'd1);
    checkOutput("single_y1", 32'(y), 32'h08);
`ifdef DEC38_SEG_EN
    checkOutput("single_seg", 32'(seg), 32'hB0);
`endif
    for (int k = 2; k <= 10; k++) begin
      idle(1);
      checkOutput("single_y_hold", 32'(y), 32'h08);
    end
    idle(1);
    checkOutput("single_y_off", 32'(y), 32'h00);

    // Index 0 without code_valid is not an event; with it, it is.
    applyStimulus(1'b1, 3'd0, 1'b0);
    idle(1);
    checkOutput("noinput_hit", 32'(hit), 32'h0);
    checkOutput("noinput_evt", 32'(evt_cnt), 32'd1);
    checkOutput("noinput_last", 32'(last_code), 32'd3);
    applyStimulus(1'b1, 3'd0, 1'b1);
    idle(1);
    checkOutput("idx0_hit", 32'(hit), 32'h01);
    checkOutput("idx0_y", 32'(y), 32'h01);
    checkOutput("idx0_evt", 32'(evt_cnt), 32'd2);
`ifdef DEC38_SEG_EN
    checkOutput("idx0_seg", 32'(seg), 32'hC0);
`endif
    idle(12);

    // Overlap: line 2 at cycle 0, line 6 at cycle 4.
    for (int c = 0; c <= 15; c++) begin
      if (c == 0)      applyStimulus(1'b1, 3'd2, 1'b1);
      else if (c == 4) applyStimulus(1'b1, 3'd6, 1'b1);
      else             idle(1);
      if (c >= 1) begin
        checkOutput("overlap_y", 32'(y),
                    (c <= 4) ? 32'h04 : (c <= 10) ? 32'h44 : (c <= 14) ? 32'h40 : 32'h00);
      end
    end
    checkOutput("overlap_evt", 32'(evt_cnt), 32'd4);

    // Retrigger: line 2 at cycle 0 and again at cycle 8.
    for (int c = 0; c <= 19; c++) begin
      if (c == 0 || c == 8) applyStimulus(1'b1, 3'd2, 1'b1);
      else                  idle(1);
      if (c >= 1) checkOutput("retrig_y2", 32'(y[2]), (c <= 18) ? 32'd1 : 32'd0);
    end
    checkOutput("retrig_evt", 32'(evt_cnt), 32'd6);

    // Enable gating while line 1 decays.
    for (int c = 0; c <= 12; c++) begin
      if (c == 0)                applyStimulus(1'b1, 3'd1, 1'b1);
      else if (c >= 3 && c <= 7) applyStimulus(1'b0, 3'd7, 1'b1);
      else                       idle(1);
      if (c >= 1) begin
        checkOutput("gate_y", 32'(y), (c <= 10) ? 32'h02 : 32'h00);
        checkOutput("gate_hit", 32'(hit), (c == 1) ? 32'h02 : 32'h00);
        checkOutput("gate_evt", 32'(evt_cnt), 32'd7);
      end
    end

    // Counter wrap: 256 back-to-back accepts cycling 0..7 from reset.
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++) applyStimulus(1'b1, 3'(k % 8), 1'b1);
    idle(1);
    checkOutput("wrap_evt", 32'(evt_cnt), 32'd0);
    checkOutput("wrap_last", 32'(last_code), 32'd7);
    checkOutput("wrap_y", 32'(y), 32'hFF);
    checkOutput("wrap_hit", 32'(hit), 32'h80);

    // Randomized traffic with occasional reset pulses, checked by the model.
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rand_async_y", 32'(y), 32'h0);
        rst_n = 1'b1;
      end
    end
    idle(HOLD_CYCLES + 2);
    checkOutput("final_y", 32'(y), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
